spi_cmd_ctrl: RTL and testbench

Command sequencer between the SPI slave byte interface and the VGA framebuffer port. It parses a byte stream (opcode, 16-bit address, payload) from the host, issues auto-incrementing framebuffer writes or reads, and stages read-back bytes for transmission. Its inputs come from the SPI receive path after clock-domain crossing, so the block is fully synchronous to the pixel/system clock.

---
 rtl/spi_cmd_ctrl_pkg.sv | 32 +++
 rtl/spi_cmd_ctrl.sv | 159 +++++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_ctrl_pkg.sv
// Shared definitions for the SPI command sequencer: opcodes, FSM states and
// the status byte returned at the start of every frame.
package spi_cmd_pkg;

    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_WRITE   = 8'h01;
    localparam logic [7:0] OP_READ    = 8'h02;
    localparam logic [7:0] OP_CLR_ERR = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        WR_DATA,
        RD_DATA,
        DISCARD
    } state_t;

    // Error flag sits in the MSB so the host can test the byte's sign.
    typedef struct packed {
        logic       err;
        logic [6:0] rsvd;
    } status_t;

    function automatic logic [7:0] status_byte(input logic err);
        status_t s;
        s.err  = err;
        s.rsvd = '0;
        return s;
    endfunction

endpackage

// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: parses opcode/address/payload bytes and drives the
// framebuffer port. Define SPI_CMD_RDBACK_EN to enable the READ command.
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_active,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              cmd_err
);

    state_t              state, state_next;
    logic [ADDR_W-1:0]   addr, addr_next;
    logic [ADDR_W-1:0]   addr_asm;
    logic [DATA_W-1:0]   addr_hi, addr_hi_next;
    logic [DATA_W-1:0]   opcode, opcode_next;
    logic                cmd_err_next;
    logic [DATA_W-1:0]   tx_next;
    logic                wr_en_next, rd_en_next;
    logic [ADDR_W-1:0]   wr_addr_next, rd_addr_next;
    logic [DATA_W-1:0]   wr_data_next;
    logic                op_read_ok;

    assign addr_asm = ADDR_W'({addr_hi, rx_data});

`ifdef SPI_CMD_RDBACK_EN
    logic rd_capture;
    assign op_read_ok = (rx_data == OP_READ);
`else
    logic rd_data_unused;
    assign op_read_ok     = 1'b0;
    assign rd_data_unused = ^rd_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr    <= '0;
            addr_hi <= '0;
            opcode  <= OP_NOP;
            cmd_err <= 1'b0;
            tx_data <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
`ifdef SPI_CMD_RDBACK_EN
            rd_capture <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            addr    <= addr_next;
            addr_hi <= addr_hi_next;
            opcode  <= opcode_next;
            cmd_err <= cmd_err_next;
            tx_data <= tx_next;
            wr_en   <= wr_en_next;
            wr_addr <= wr_addr_next;
            wr_data <= wr_data_next;
            rd_en   <= rd_en_next;
            rd_addr <= rd_addr_next;
`ifdef SPI_CMD_RDBACK_EN
            rd_capture <= rd_en;
`endif
        end
    end

    // Chip-select low overrides everything, including a byte arriving in the
    // same cycle, so an aborted frame never produces a framebuffer access.
    always_comb begin
        state_next   = state;
        addr_next    = addr;
        addr_hi_next = addr_hi;
        opcode_next  = opcode;
        cmd_err_next = cmd_err;
        tx_next      = tx_data;
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr;
        wr_data_next = wr_data;
        rd_en_next   = 1'b0;
        rd_addr_next = rd_addr;

`ifdef SPI_CMD_RDBACK_EN
        if (rd_capture)
            tx_next = rd_data;
`endif

        if (!cs_active) begin
            state_next   = IDLE;
            opcode_next  = OP_NOP;
            addr_hi_next = '0;
            tx_next      = DATA_W'(status_byte(cmd_err));
        end else if (rx_valid) begin
            case (state)
                IDLE: begin
                    opcode_next = rx_data;
                    if (rx_data == OP_WRITE || op_read_ok) begin
                        state_next = ADDR_HI;
                    end else begin
                        state_next = DISCARD;
                        if (rx_data == OP_CLR_ERR)
                            cmd_err_next = 1'b0;
                        else if (rx_data != OP_NOP)
                            cmd_err_next = 1'b1;
                    end
                end
                ADDR_HI: begin
                    addr_hi_next = rx_data;
                    state_next   = ADDR_LO;
                end
                ADDR_LO: begin
                    addr_next = addr_asm;
                    if (opcode == OP_WRITE) begin
                        state_next = WR_DATA;
                    end else begin
`ifdef SPI_CMD_RDBACK_EN
                        state_next   = RD_DATA;
                        rd_en_next   = 1'b1;
                        rd_addr_next = addr_asm;
`else
                        state_next   = DISCARD;
`endif
                    end
                end
                WR_DATA: begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = addr;
                    wr_data_next = rx_data;
                    addr_next    = addr + ADDR_W'(1);
                end
                RD_DATA: begin
`ifdef SPI_CMD_RDBACK_EN
                    rd_en_next   = 1'b1;
                    rd_addr_next = addr + ADDR_W'(1);
                    addr_next    = addr + ADDR_W'(1);
`else
                    state_next   = DISCARD;
`endif
                end
                DISCARD: ;
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed testbench for spi_cmd_ctrl with a small synchronous framebuffer
// model and a log of every write/read strobe seen.
module tb_spi_cmd_ctrl;
    import spi_cmd_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_active = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [7:0]  tx_data;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data = 8'h00;
    logic        cmd_err;

    int n_checks = 0;
    int n_fail   = 0;
    int both_cnt = 0;
    logic [15:0] wr_a[$];
    logic [7:0]  wr_d[$];
    logic [15:0] rd_a[$];

    spi_cmd_ctrl #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cs_active (cs_active),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_data   (tx_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    // Synchronous framebuffer: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en)
            rd_data <= (rd_addr == 16'h2000) ? 8'h5A :
                       (rd_addr == 16'h2001) ? 8'hC3 : 8'hEE;
    end

    always @(negedge clk) begin
        if (wr_en) begin
            wr_a.push_back(wr_addr);
            wr_d.push_back(wr_data);
        end
        if (rd_en)
            rd_a.push_back(rd_addr);
        if (wr_en && rd_en)
            both_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic openFrame();
        @(negedge clk);
        cs_active = 1'b1;
    endtask

    task automatic closeFrame();
        @(negedge clk);
        cs_active = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic clearLogs();
        wr_a.delete();
        wr_d.delete();
        rd_a.delete();
    endtask

    task automatic expectWrite(input string tag, input int idx, input logic [15:0] a, input logic [7:0] d);
        checkOutput({tag, "_addr"}, (idx < wr_a.size()) ? 32'(wr_a[idx]) : 32'hxxxxxxxx, 32'(a));
        checkOutput({tag, "_data"}, (idx < wr_d.size()) ? 32'(wr_d[idx]) : 32'hxxxxxxxx, 32'(d));
    endtask

    task automatic expectRead(input string tag, input int idx, input logic [15:0] a);
        checkOutput(tag, (idx < rd_a.size()) ? 32'(rd_a[idx]) : 32'hxxxxxxxx, 32'(a));
    endtask

    initial begin
        $display("[TB] start");
        repeat (3) @(negedge clk);
        checkOutput("rst_tx", 32'(tx_data), 32'h00);
        checkOutput("rst_wr_en", 32'(wr_en), 32'h0);
        checkOutput("rst_rd_en", 32'(rd_en), 32'h0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'h0);
        checkOutput("rst_wr_data", 32'(wr_data), 32'h0);
        checkOutput("rst_rd_addr", 32'(rd_addr), 32'h0);
        checkOutput("rst_cmd_err", 32'(cmd_err), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // WRITE burst
        clearLogs();
        openFrame();
        applyStimulus(8'h01); applyStimulus(8'h12); applyStimulus(8'h34);
        applyStimulus(8'hAA); applyStimulus(8'hBB); applyStimulus(8'hCC);
        closeFrame();
        checkOutput("burst_wr_cnt", 32'(wr_a.size()), 32'd3);
        expectWrite("burst0", 0, 16'h1234, 8'hAA);
        expectWrite("burst1", 1, 16'h1235, 8'hBB);
        expectWrite("burst2", 2, 16'h1236, 8'hCC);
        checkOutput("burst_rd_cnt", 32'(rd_a.size()), 32'd0);
        checkOutput("burst_status", 32'(tx_data), 32'h00);

        // Address wrap
        clearLogs();
        openFrame();
        applyStimulus(8'h01); applyStimulus(8'hFF); applyStimulus(8'hFF);
        applyStimulus(8'h11); applyStimulus(8'h22);
        closeFrame();
        checkOutput("wrap_wr_cnt", 32'(wr_a.size()), 32'd2);
        expectWrite("wrap0", 0, 16'hFFFF, 8'h11);
        expectWrite("wrap1", 1, 16'h0000, 8'h22);

        // READ
        clearLogs();
        openFrame();
        applyStimulus(8'h02); applyStimulus(8'h20); applyStimulus(8'h00);
`ifdef SPI_CMD_RDBACK_EN
        checkOutput("read_tx0", 32'(tx_data), 32'h5A);
        applyStimulus(8'hFF);
        checkOutput("read_tx1", 32'(tx_data), 32'hC3);
        checkOutput("read_rd_cnt", 32'(rd_a.size()), 32'd2);
        expectRead("read_addr0", 0, 16'h2000);
        expectRead("read_addr1", 1, 16'h2001);
        checkOutput("read_err", 32'(cmd_err), 32'h0);
        closeFrame();
        checkOutput("read_status", 32'(tx_data), 32'h00);
`else
        applyStimulus(8'hFF);
        checkOutput("noread_err", 32'(cmd_err), 32'h1);
        checkOutput("noread_rd_cnt", 32'(rd_a.size()), 32'd0);
        checkOutput("noread_tx", 32'(tx_data), 32'h00);
        closeFrame();
        checkOutput("noread_status", 32'(tx_data), 32'h80);
        openFrame();
        applyStimulus(8'h03);
        closeFrame();
        checkOutput("noread_clr", 32'(cmd_err), 32'h0);
`endif
        checkOutput("read_wr_cnt", 32'(wr_a.size()), 32'd0);

        // Unknown opcode, then clear
        clearLogs();
        openFrame();
        applyStimulus(8'h7E); applyStimulus(8'h01); applyStimulus(8'h00);
        applyStimulus(8'h00); applyStimulus(8'h55);
        checkOutput("unk_err", 32'(cmd_err), 32'h1);
        checkOutput("unk_wr_cnt", 32'(wr_a.size()), 32'd0);
        closeFrame();
        checkOutput("unk_status", 32'(tx_data), 32'h80);
        openFrame();
        applyStimulus(8'h03);
        checkOutput("clr_err", 32'(cmd_err), 32'h0);
        closeFrame();
        checkOutput("clr_status", 32'(tx_data), 32'h00);

        // Abort: chip-select drops together with a data byte
        clearLogs();
        openFrame();
        applyStimulus(8'h01); applyStimulus(8'h00); applyStimulus(8'h10);
        @(negedge clk);
        rx_valid  = 1'b1;
        rx_data   = 8'h99;
        cs_active = 1'b0;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("abort_wr_cnt", 32'(wr_a.size()), 32'd0);
        checkOutput("abort_state", 32'(dut.state), 32'(IDLE));
        openFrame();
        applyStimulus(8'h01); applyStimulus(8'h00); applyStimulus(8'h20);
        applyStimulus(8'h44);
        closeFrame();
        checkOutput("abort_next_cnt", 32'(wr_a.size()), 32'd1);
        expectWrite("abort_next", 0, 16'h0020, 8'h44);

        // Reset in the middle of a write burst
        clearLogs();
        openFrame();
        applyStimulus(8'h01); applyStimulus(8'h00); applyStimulus(8'h40);
        applyStimulus(8'hAB);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'hCD;
        rst      = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        checkOutput("mid_rst_wr_en", 32'(wr_en), 32'h0);
        checkOutput("mid_rst_wr_addr", 32'(wr_addr), 32'h0);
        checkOutput("mid_rst_wr_data", 32'(wr_data), 32'h0);
        checkOutput("mid_rst_rd_en", 32'(rd_en), 32'h0);
        checkOutput("mid_rst_tx", 32'(tx_data), 32'h00);
        checkOutput("mid_rst_cmd_err", 32'(cmd_err), 32'h0);
        checkOutput("mid_rst_state", 32'(dut.state), 32'(IDLE));
        checkOutput("mid_rst_wr_cnt", 32'(wr_a.size()), 32'd1);
        expectWrite("mid_rst_first", 0, 16'h0040, 8'hAB);
        rst = 1'b0;
        closeFrame();
        clearLogs();
        openFrame();
        applyStimulus(8'h01); applyStimulus(8'h00); applyStimulus(8'h00);
        applyStimulus(8'h77);
        closeFrame();
        checkOutput("post_rst_cnt", 32'(wr_a.size()), 32'd1);
        expectWrite("post_rst", 0, 16'h0000, 8'h77);

        checkOutput("never_both", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
